rr_mux4: RTL and testbench

Four-channel round-robin multiplexer with a registered output. It gathers words from four independent valid/ready sources onto one shared stream. Each output word carries its 2-bit source index on `d_sel`, so the downstream `demux` can route it back to the matching `d_out_n`. The block sits upstream of `demux` in the shared-link path.

---
 rtl/rr_mux4.sv | 100 ++++++++++
 tb/tb_rr_mux4.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// rtl/rr_mux4.sv - four-channel round-robin valid/ready multiplexer with registered output
module rr_mux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in_0,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [WIDTH-1:0] d_in_3,
    input  logic [3:0]       d_vld,
    output logic [3:0]       d_rdy,
    output logic [WIDTH-1:0] d_out,
    output logic [1:0]       d_sel,
    output logic             d_out_vld,
    input  logic             d_out_rdy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;

    logic [1:0]       winner;
    logic             found;
    logic [1:0]       idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] win_data;

    // Pick the first requesting channel after the most recent grant; last_q itself is searched last.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + i[1:0];
            if (!found && d_vld[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Data of the winning channel.
    always_comb begin
        win_data = d_in_0;
        case (winner)
            2'd0:    win_data = d_in_0;
            2'd1:    win_data = d_in_1;
            2'd2:    win_data = d_in_2;
            default: win_data = d_in_3;
        endcase
    end

    // Next-state and handshake logic; reset masks d_rdy so nothing is consumed while held in reset.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sel_d   = sel_q;
        last_d  = last_q;
        load_en = (state_q == EMPTY) || d_out_rdy;
        xfer    = rst_n && load_en && found;
        d_rdy   = 4'b0000;
        if (xfer) begin
            d_rdy[winner] = 1'b1;
            state_d       = FULL;
            out_d         = win_data;
            sel_d         = winner;
            last_d        = winner;
        end else if (state_q == FULL && d_out_rdy) begin
            state_d = EMPTY;
        end
    end

    // Output register and arbitration pointer; last_q resets to 3 so channel 0 goes first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign d_out     = out_q;
    assign d_sel     = sel_q;
    assign d_out_vld = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux4.sv
// tb/tb_rr_mux4.sv - table-driven directed bench for rr_mux4
module tb_rr_mux4;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d_in_0, d_in_1, d_in_2, d_in_3;
    logic [3:0]   d_vld;
    logic [3:0]   d_rdy;
    logic [W-1:0] d_out;
    logic [1:0]   d_sel;
    logic         d_out_vld;
    logic         d_out_rdy;

    int total;
    int bad;

    rr_mux4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in_0    (d_in_0),
        .d_in_1    (d_in_1),
        .d_in_2    (d_in_2),
        .d_in_3    (d_in_3),
        .d_vld     (d_vld),
        .d_rdy     (d_rdy),
        .d_out     (d_out),
        .d_sel     (d_sel),
        .d_out_vld (d_out_vld),
        .d_out_rdy (d_out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic [3:0]   vld;
        logic         ordy;
        logic [3:0]   exp_rdy;
        logic         exp_ovld;
        logic [1:0]   exp_sel;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vec [25];
    int   nvec;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic o,
                       input logic [3:0] er, input logic ev, input logic [1:0] es, input logic [W-1:0] eo);
        vec[nvec] = '{rst: r, vld: v, ordy: o, exp_rdy: er, exp_ovld: ev, exp_sel: es, exp_out: eo};
        nvec++;
    endtask

    // Drive at negedge, check combinational ready before the edge, registered outputs after it.
    task automatic step(input int idx, input vec_t v);
        @(negedge clk);
        rst_n     = v.rst;
        d_vld     = v.vld;
        d_out_rdy = v.ordy;
        #1;
        check("d_rdy", idx, 32'(d_rdy), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check("d_out_vld", idx, 32'(d_out_vld), 32'(v.exp_ovld));
        check("d_sel", idx, 32'(d_sel), 32'(v.exp_sel));
        check("d_out", idx, 32'(d_out), 32'(v.exp_out));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        nvec      = 0;
        rst_n     = 1'b0;
        d_vld     = 4'b0000;
        d_out_rdy = 1'b0;
        d_in_0    = 8'hA1;
        d_in_1    = 8'hB0;
        d_in_2    = 8'hC5;
        d_in_3    = 8'hD3;

        // reset with all channels requesting
        add(1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
        add(1'b0, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        // full rotation, two laps
        add(1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1);
        add(1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB0);
        add(1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC5);
        add(1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1);
        add(1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB0);
        add(1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC5);
        add(1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3);
        // sparse: channel 2, then channel 1 via wrap 3,0,1
        add(1'b1, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC5);
        add(1'b1, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB0);
        // backpressure for three cycles, then channel 2 granted
        add(1'b1, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB0);
        add(1'b1, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB0);
        add(1'b1, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB0);
        add(1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC5);
        // drain-and-refill from channel 3, then drain to empty
        add(1'b1, 4'h8, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hD3);
        // idle does not move the pointer; empty register loads even with d_out_rdy low
        add(1'b1, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'hD3);
        add(1'b1, 4'h4, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hC5);
        // reset mid-stream, next grant is channel 0
        add(1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
        add(1'b1, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA1);
        // pointer channel searched last, and wrap after 3
        add(1'b1, 4'h1, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1);
        add(1'b1, 4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3);
        add(1'b1, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA1);

        for (int i = 0; i < nvec; i++) begin
            step(i, vec[i]);
        end

        // Held word must not follow a changing source while stalled.
        @(negedge clk);
        d_vld     = 4'hF;
        d_out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_in_0 = 8'h5E + 8'(k);
            #1;
            check("stall_rdy", 100 + k, 32'(d_rdy), 32'h0);
            @(posedge clk);
            #1;
            check("stall_out", 100 + k, 32'(d_out), 32'hA1);
            check("stall_vld", 100 + k, 32'(d_out_vld), 32'h1);
            @(negedge clk);
        end
        d_in_0    = 8'hA1;
        d_out_rdy = 1'b1;
        #1;
        check("release_rdy", 103, 32'(d_rdy), 32'h2);
        @(posedge clk);
        #1;
        check("release_sel", 103, 32'(d_sel), 32'h1);
        check("release_out", 103, 32'(d_out), 32'hB0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
